// File: rtl/dm_cache_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : dm_cache_ctrl_pkg
// Brief    : Shared types, constants and width helpers for the direct-mapped
//            write-back data cache.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dm_cache_ctrl_pkg;

  localparam int ADDR_W        = 32;
  localparam int WORD_W        = 32;
  localparam int BLOCK_SIZE    = 16;
  localparam int WORD_OFFSET_W = 2;
  localparam int BYTE_OFFSET_W = 2;
  localparam int OFFSET_W      = WORD_OFFSET_W + BYTE_OFFSET_W;
  localparam int LINE_W        = BLOCK_SIZE * 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    WB_WAIT   = 3'd3,
    ALLOCATE  = 3'd4,
    AL_WAIT   = 3'd5
  } state_t;

  // Number of address bits selecting a line
  function automatic int calc_index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Address bits left over for the tag once offset and index are removed
  function automatic int calc_tag_w(input int num_sets);
    return ADDR_W - OFFSET_W - $clog2(num_sets);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_cache_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : dm_cache_ctrl_if
// Brief    : CPU request/response bus and block-granular memory handshake.
//            master = cache controller view, slave = CPU/memory environment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dm_cache_ctrl_if #(
  parameter int MEM_ADDR_W = 32
);
  // CPU side
  logic                  is_input_valid;
  logic [31:0]           addr;
  logic                  mem_rw;
  logic [31:0]           din;
  logic                  is_ready;
  logic                  is_output_valid;
  logic [31:0]           dout;
  logic                  is_hit;
  // Memory side
  logic                  mem_is_input_valid;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [127:0]          mem_din;
  logic                  mem_is_output_valid;
  logic [127:0]          mem_dout;
  logic                  mem_ready;

  modport master (
    input  is_input_valid, addr, mem_rw, din,
    output is_ready, is_output_valid, dout, is_hit,
    output mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din,
    input  mem_is_output_valid, mem_dout, mem_ready
  );

  modport slave (
    output is_input_valid, addr, mem_rw, din,
    input  is_ready, is_output_valid, dout, is_hit,
    input  mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din,
    output mem_is_output_valid, mem_dout, mem_ready
  );

endinterface

`default_nettype wire

// File: rtl/dm_cache_array.sv
//------------------------------------------------------------------------------
// Module   : dm_cache_array
// Brief    : Tag/valid/dirty/data storage for the direct-mapped cache.
//            Single-cycle word-write and line-fill ports, plus dirty clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_cache_array
  import dm_cache_ctrl_pkg::*;
#(
  parameter  int NUM_SETS = 16,
  parameter  int TAG_W    = 24,
  localparam int INDEX_W  = calc_index_w(NUM_SETS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INDEX_W-1:0]       index,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [LINE_W-1:0]        rd_line,
  input  logic                     word_we,
  input  logic [WORD_OFFSET_W-1:0] word_sel,
  input  logic [WORD_W-1:0]        word_data,
  input  logic                     fill_en,
  input  logic [TAG_W-1:0]         fill_tag,
  input  logic [LINE_W-1:0]        fill_line,
  input  logic                     clean_en
);

  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   r_data_mem [NUM_SETS];

  assign rd_valid = r_valid[index];
  assign rd_dirty = r_dirty[index];
  assign rd_tag   = r_tag_mem[index];
  assign rd_line  = r_data_mem[index];

  // Line status: a fill makes a clean valid line, a store dirties it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (fill_en) begin
      r_valid[index] <= 1'b1;
      r_dirty[index] <= 1'b0;
    end else if (word_we) begin
      r_dirty[index] <= 1'b1;
    end else if (clean_en) begin
      r_dirty[index] <= 1'b0;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (fill_en) begin
      r_tag_mem[index]  <= fill_tag;
      r_data_mem[index] <= fill_line;
    end else if (word_we) begin
      r_data_mem[index][{word_sel, 5'd0} +: WORD_W] <= word_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
//------------------------------------------------------------------------------
// Module   : dm_cache_ctrl
// Brief    : Direct-mapped, write-back, write-allocate data cache controller.
//            Stalls the CPU via is_ready while writing back / refilling.
//            Optional: define CACHE_STATS_EN for saturating hit/miss counters
//            (num_hits, num_misses).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_cache_ctrl #(
  parameter int NUM_SETS   = 16,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  dm_cache_ctrl_if.master      bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]          num_hits,
  output logic [31:0]          num_misses
`endif
);

  import dm_cache_ctrl_pkg::*;

  localparam int INDEX_W  = calc_index_w(NUM_SETS);
  localparam int TAG_W    = calc_tag_w(NUM_SETS);
  localparam int OFF_W    = $clog2(BLOCK_SIZE);
  localparam int BLK_W    = TAG_W + INDEX_W;

  state_t r_state;
  state_t w_next;

  // Latched request
  logic [TAG_W-1:0]         r_tag;
  logic [INDEX_W-1:0]       r_index;
  logic [WORD_OFFSET_W-1:0] r_word;
  logic                     r_rw;
  logic [WORD_W-1:0]        r_din;
  logic                     r_missed;

  // Array read side
  logic                     w_valid;
  logic                     w_dirty;
  logic [TAG_W-1:0]         w_line_tag;
  logic [LINE_W-1:0]        w_line;
  logic [WORD_W-1:0]        w_word;

  // Control
  logic                     w_accept;
  logic                     w_hit;
  logic                     w_resp;
  logic                     w_word_we;
  logic                     w_fill_en;
  logic                     w_clean_en;
  logic                     w_mem_valid;
  logic                     w_mem_read;
  logic                     w_mem_write;
  logic [BLK_W-1:0]         w_mem_blk;
  logic [LINE_W-1:0]        w_mem_din;

  // Registered CPU response
  logic                     r_out_valid;
  logic                     r_out_hit;
  logic [WORD_W-1:0]        r_dout;

  dm_cache_array #(
    .NUM_SETS (NUM_SETS),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (r_index),
    .rd_valid  (w_valid),
    .rd_dirty  (w_dirty),
    .rd_tag    (w_line_tag),
    .rd_line   (w_line),
    .word_we   (w_word_we),
    .word_sel  (r_word),
    .word_data (r_din),
    .fill_en   (w_fill_en),
    .fill_tag  (r_tag),
    .fill_line (bus.mem_dout),
    .clean_en  (w_clean_en)
  );

  assign w_accept = (r_state == IDLE) && bus.is_input_valid;
  assign w_hit    = w_valid && (w_line_tag == r_tag);
  assign w_resp   = (r_state == COMPARE) && w_hit;
  assign w_word   = w_line[{r_word, 5'd0} +: WORD_W];

  // Capture the request so the lookup works from stable values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag   <= '0;
      r_index <= '0;
      r_word  <= '0;
      r_rw    <= 1'b0;
      r_din   <= '0;
    end else if (w_accept) begin
      r_tag   <= bus.addr[31 -: TAG_W];
      r_index <= bus.addr[OFF_W +: INDEX_W];
      r_word  <= bus.addr[BYTE_OFFSET_W +: WORD_OFFSET_W];
      r_rw    <= bus.mem_rw;
      r_din   <= bus.din;
    end
  end

  // Remember whether this request already took a miss, so the re-lookup is not reported as a hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_missed <= 1'b0;
    end else if (w_accept) begin
      r_missed <= 1'b0;
    end else if ((r_state == COMPARE) && !w_hit) begin
      r_missed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic; memory requests only advance on mem_ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (bus.is_input_valid) w_next = COMPARE;
      COMPARE: begin
        if (w_hit)                 w_next = IDLE;
        else if (w_valid && w_dirty) w_next = WRITEBACK;
        else                       w_next = ALLOCATE;
      end
      WRITEBACK: if (bus.mem_ready) w_next = WB_WAIT;
      WB_WAIT:   if (bus.mem_ready) w_next = ALLOCATE;
      ALLOCATE:  if (bus.mem_ready) w_next = AL_WAIT;
      AL_WAIT:   if (bus.mem_is_output_valid) w_next = COMPARE;
      default:   w_next = IDLE;
    endcase
  end

  // FSM outputs: memory request lines and array write strobes
  always_comb begin
    w_mem_valid = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_blk   = '0;
    w_mem_din   = '0;
    w_word_we   = 1'b0;
    w_fill_en   = 1'b0;
    w_clean_en  = 1'b0;
    case (r_state)
      COMPARE:   w_word_we = w_hit && r_rw;
      WRITEBACK: begin
        w_mem_valid = 1'b1;
        w_mem_write = 1'b1;
        w_mem_blk   = {w_line_tag, r_index};
        w_mem_din   = w_line;
      end
      WB_WAIT:   w_clean_en = bus.mem_ready;
      ALLOCATE: begin
        w_mem_valid = 1'b1;
        w_mem_read  = 1'b1;
        w_mem_blk   = {r_tag, r_index};
      end
      AL_WAIT:   w_fill_en = bus.mem_is_output_valid;
      default: ;
    endcase
  end

  // CPU response: one-cycle pulse when the lookup hits, load data held until the next load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_out_valid <= w_resp;
      r_out_hit   <= w_resp && !r_missed;
      if (w_resp && !r_rw) begin
        r_dout <= w_word;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_hits   <= '0;
      num_misses <= '0;
    end else begin
      if (w_resp && !r_missed && (num_hits != 32'hFFFF_FFFF)) begin
        num_hits <= num_hits + 32'd1;
      end
      if ((r_state == COMPARE) && !w_hit && (num_misses != 32'hFFFF_FFFF)) begin
        num_misses <= num_misses + 32'd1;
      end
    end
  end
`endif

  assign bus.is_ready           = (r_state == IDLE);
  assign bus.is_output_valid    = r_out_valid;
  assign bus.is_hit             = r_out_hit;
  assign bus.dout               = r_dout;
  assign bus.mem_is_input_valid = w_mem_valid;
  assign bus.mem_read           = w_mem_read;
  assign bus.mem_write          = w_mem_write;
  assign bus.mem_addr           = MEM_ADDR_W'(w_mem_blk);
  assign bus.mem_din            = w_mem_din;

endmodule

`default_nettype wire

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU memory stage and the multi-cycle block-granular data memory.
- Acts as the initiator on the memory request/response handshake.
- Stalls the CPU via is_ready while it writes back a dirty line and refills a block.

Parameters:
- NUM_SETS, 16, number of lines; power of two, at least 2.
- BLOCK_SIZE, 16, line size in bytes; fixed at 16, i.e. 4 words of 32 bits.
- MEM_ADDR_W, 32, width of the memory-side block address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- is_input_valid  input  1  CPU request valid.
- addr  input  32  CPU byte address. Fields: word = [3:2], index = next log2(NUM_SETS) bits, tag = remaining upper bits.
- mem_rw  input  1  1 = store, 0 = load.
- din  input  32  store data.
- is_ready  output  1  cache can accept a request this cycle.
- is_output_valid  output  1  one-cycle pulse when a request completes.
- dout  output  32  load data; valid only with is_output_valid.
- is_hit  output  1  pulses with is_output_valid when the access hit on first lookup.
- mem_is_input_valid  output  1  memory request valid.
- mem_addr  output  MEM_ADDR_W  block address = byte address >> 4.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- mem_din  output  128  line written back to memory.
- mem_is_output_valid  input  1  memory read data valid.
- mem_dout  input  128  memory read data.
- mem_ready  input  1  memory idle; a request is accepted when mem_ready and mem_is_input_valid are both high at a rising edge.

Behaviour:
- Reset:
  - All valid and dirty bits cleared; state goes to IDLE.
  - Outputs: is_ready=1; is_output_valid, is_hit, mem_is_input_valid, mem_read, mem_write = 0; dout, mem_addr, mem_din = 0.
  - Tag and data arrays need not be cleared.
- States:
  - IDLE: is_ready=1. If is_input_valid, latch addr/mem_rw/din and go to COMPARE.
  - COMPARE: is_ready=0. Hit = valid && tag match.
    - First-lookup hit (no miss serviced for this request): pulse is_output_valid and is_hit.
    - Load hit: dout = selected word.
    - Store hit: write the word and set dirty.
    - Any hit returns to IDLE.
    - Miss on a dirty line goes to WRITEBACK; any other miss goes to ALLOCATE.
  - WRITEBACK: drive mem_is_input_valid=1, mem_write=1, mem_addr={old tag, index}, mem_din = line. Hold until an edge with mem_ready=1, then go to WB_WAIT.
  - WB_WAIT: on the first cycle with mem_ready=1, clear dirty and go to ALLOCATE.
  - ALLOCATE: drive mem_is_input_valid=1, mem_read=1, mem_addr={new tag, index}. Hold until accepted, then go to AL_WAIT.
  - AL_WAIT: on mem_is_output_valid, write mem_dout into the line, set valid, clear dirty, load the new tag, and go to COMPARE. The re-lookup now hits but reports is_hit=0.
- Memory-side outputs are 0 outside WRITEBACK and ALLOCATE.
- Latency, with memory DELAY=D and acceptance edge = cycle 0:
  - hit: response in cycle 1.
  - clean miss: response in cycle D+4.
  - dirty miss: response in cycle 2D+6.
- is_ready=0 outside IDLE; is_input_valid in those cycles is ignored and not queued.
- Issuing only when mem_ready=1 tolerates a memory still busy from before a reset.
- Asynchronous reset mid-miss abandons the transaction. No partial line is ever marked valid.
- Only whole lines travel on the memory side; memory data is never written partially.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs num_hits[31:0] and num_misses[31:0].
  - num_hits increments on each is_hit pulse.
  - num_misses increments on each COMPARE→WRITEBACK or COMPARE→ALLOCATE transition.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: neither port nor counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state enum (IDLE, COMPARE, WRITEBACK, WB_WAIT, ALLOCATE, AL_WAIT);
  - BLOCK_SIZE, WORD_OFFSET_W=2, BYTE_OFFSET_W=2;
  - a function computing index/tag widths from NUM_SETS.
- One sub-module, dm_cache_array: tag/valid/dirty/data storage with a word-write port and a line-fill port, both single-cycle. The FSM stays in dm_cache_ctrl.

Test Plan:
- After reset, load addr 0x0000_0040 with memory preloaded and D=50 → is_output_valid in cycle 54, is_hit=0, dout = block 0x4 word 0; then a load of 0x0000_0044 → response in cycle 1, is_hit=1.
- Store 0xDEADBEEF to 0x40 (hit), then load 0x40+NUM_SETS·16 (same index) → write-back of block 0x4 with word 0 = 0xDEADBEEF, then refill; response in cycle 106.
- Assert is_input_valid continuously during a miss → no extra request accepted; is_ready=0 until the response cycle.
- Hold mem_ready low for 10 extra cycles in ALLOCATE → mem_is_input_valid stays high with stable mem_addr until accepted.
- Assert reset low in AL_WAIT, then reload the same address → miss again (is_hit=0); no stale valid line.
- With CACHE_STATS_EN: 3 hits, 2 misses → num_hits=3, num_misses=2.
